ff_pipe: RTL and testbench
==========================

// Module: ff_pipe
// PURPOSE
//  Parametrised elastic register pipeline: DEPTH stages of N-bit data, each with a valid bit.
//  Valid/ready handshake on both ends; interior bubbles collapse.
//  Synchronous flush and an occupancy count are provided.
//  Used between SHA-512 core stages and the unit's input/output buffers.
//  It replaces bare enable/reset flop registers wherever back-pressure must be absorbed.
// PARAMETERS
//  N        64  data width in bits (>=1)
//  DEPTH    4   number of register stages (>=1; elaboration error otherwise)
//  RST_DATA 0   1: data flops clear to 0 on rst; 0: only valid bits and occupancy reset
// PORTS
//  CLK        in   1                  clock, all logic on posedge
//  rst        in   1                  synchronous reset, active-high
//  flush      in   1                  synchronous discard of all held words
//  in_valid   in   1                  upstream word present on i
//  in_ready   out  1                  pipeline accepts i this cycle
//  i          in   N                  input data
//  out_valid  out  1                  word present on o
//  out_ready  in   1                  downstream takes o this cycle
//  o          out  N                  output data (stage DEPTH-1)
//  occupancy  out  $clog2(DEPTH+1)    number of valid stages, 0..DEPTH
// BEHAVIOUR
//  - Reset: valid[*]=0, out_valid=0, occupancy=0, in_ready=1 on the first cycle after rst.
//    Data flops clear to 0 if RST_DATA=1, otherwise they hold.
//    rst mid-transfer drops every held word; rst takes priority over flush and the handshakes.
//  - Stage k (0..DEPTH-1) holds v[k] and d[k].
//    ready[DEPTH] = out_ready; ready[k] = !v[k] | ready[k+1].
//    Stage k loads from k-1 (or from i when k=0) when ready[k] is high.
//    On load: v[k] <= v[k-1] (or in_valid), d[k] <= source data only when the source valid is 1.
//    Data flops never toggle on bubbles.
//  - in_ready = ready[0] & !flush. This is combinational through the ready chain, with no register on the ready path.
//  - Transfers: accept = in_valid & in_ready; take = out_valid & out_ready.
//  - Latency: a word accepted at cycle t appears on o with out_valid=1 at cycle t+DEPTH when unstalled.
//    With an empty pipe it is always exactly DEPTH. Throughput is 1 word/cycle.
//  - Stall: with out_ready=0 the pipe fills; in_ready falls when all DEPTH stages are valid.
//    The DEPTH+1th word is refused. o and out_valid stay stable while stalled (AXI-style hold).
//  - Bubble collapse: a valid word advances into an empty downstream stage even while out_ready=0.
//  - Full and out_ready=1: in_ready=1 in the same cycle, so simultaneous accept and take give zero throughput loss.
//  - occupancy: +1 on accept only, -1 on take only, unchanged on both or neither.
//    Always equals popcount(v). It never exceeds DEPTH and never underflows.
//  - flush: next cycle all v=0 and occupancy=0.
//    A word offered in the flush cycle is not accepted (in_ready=0).
//    A take in the flush cycle still completes downstream. Data flops are unchanged.
//  - o holds the last loaded d[DEPTH-1] when out_valid=0. Only o qualified by out_valid is meaningful.
//  - DEPTH=1 degenerates to a single-register full-throughput stage with the same rules.
// STRUCTURE
//  - Width and depth come only from parameters; no new typedefs are needed.
//  - The occupancy width function goes in the shared sha512 header as a constant function/macro (clog2).
//  - Sub-module ff_pipe_stage: one valid flop plus N data flops with load enable and RST_DATA option.
//    ff_pipe generates DEPTH instances and the ready chain, and keeps the occupancy counter.
// TESTING
//  1 N=64,DEPTH=4: rst, then stream 0x1..0x10 with out_ready=1
//    -> 0x1 on o at t+4, one word per cycle, in order, occupancy steady at 4.
//  2 out_ready=0, push 6 words -> exactly 4 accepted, in_ready=0 after the 4th, occupancy=4, o=0x1 held stable.
//  3 Full pipe, in_valid=1, out_ready=1 for 8 cycles
//    -> 8 accepts and 8 takes, occupancy stays 4, no gap in out_valid.
//  4 Push 2 words with out_ready=0, idle 3 cycles
//    -> both words collapse to stages 3 and 2, occupancy=2; then out_ready=1 -> taken on 2 consecutive cycles.
//  5 Occupancy 3, assert flush with in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0, occupancy=0.
//    The next word's latency is 4.
//  6 rst mid-stream with RST_DATA=1 -> o=0, out_valid=0, occupancy=0 next cycle.
//    Repeat with RST_DATA=0 -> o holds its last value.
//  Scoreboard compares data order on every take; an assertion checks occupancy==popcount(v) every cycle.

Source files
------------

// File: rtl/ff_pipe_pkg.sv
// ff_pipe_pkg
//   Shared helpers for the elastic register pipeline.
//   ff_clog2      : ceiling log2 as a constant function, usable in port widths
//   ff_occ_width  : width of a counter holding 0..depth, never less than 1
package ff_pipe_pkg;

    function automatic int ff_clog2(input int value);
        int result;
        result = 0;
        for (int w = value - 1; w > 0; w = w >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int ff_occ_width(input int depth);
        int w;
        w = ff_clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ff_pipe_stage.sv
// ff_pipe_stage
//   One stage of the elastic pipeline: a valid flop plus N data flops.
//   Ports:
//     clk_i        clock
//     rst_i        synchronous active-high reset (clears valid; data too if RST_DATA)
//     flush_i      clears valid, data untouched
//     load_i       stage takes src_valid_i (and src_data_i when that is valid)
//     src_valid_i  valid bit of the upstream source
//     src_data_i   data of the upstream source
//     valid_o      held valid bit
//     data_o       held data word
module ff_pipe_stage
    import ff_pipe_pkg::*;
#(
    parameter int N        = 64,
    parameter bit RST_DATA = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         src_valid_i,
    input  logic [N-1:0] src_data_i,
    output logic         valid_o,
    output logic [N-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    // Data only captures real words, so bubbles moving through never toggle it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = src_valid_i;
            if (src_valid_i) begin
                data_d = src_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            if (RST_DATA) begin
                data_q <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ff_pipe.sv
// ff_pipe
//   Elastic register pipeline of DEPTH stages with valid/ready on both ends.
//   Interior bubbles collapse; a full pipe with out_ready=1 keeps accepting.
//   Ports:
//     CLK        clock, all logic on posedge
//     rst        synchronous active-high reset, beats flush and handshakes
//     flush      synchronous discard of all held words
//     in_valid   upstream word present on i
//     in_ready   pipeline accepts i this cycle (combinational ready chain)
//     i          input data
//     out_valid  word present on o
//     out_ready  downstream takes o this cycle
//     o          output data (last stage)
//     occupancy  number of valid stages, 0..DEPTH
module ff_pipe
    import ff_pipe_pkg::*;
#(
    parameter int N        = 64,
    parameter int DEPTH    = 4,
    parameter bit RST_DATA = 1'b0
) (
    input  logic                             CLK,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N-1:0]                     i,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N-1:0]                     o,
    output logic [ff_occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = ff_occ_width(DEPTH);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("ff_pipe: DEPTH must be >= 1");
        end
        if (N < 1) begin : g_bad_width
            $error("ff_pipe: N must be >= 1");
        end
    endgenerate

    logic [DEPTH-1:0] v;
    logic [DEPTH:0]   ready;
    logic [N-1:0]     d [DEPTH];

    // A stage can load when it is empty or its own word is leaving this cycle.
    assign ready[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        assign ready[k] = !v[k] | ready[k+1];

        if (k == 0) begin : g_head
            ff_pipe_stage #(.N(N), .RST_DATA(RST_DATA)) u_stage (
                .clk_i       (CLK),
                .rst_i       (rst),
                .flush_i     (flush),
                .load_i      (ready[k]),
                .src_valid_i (in_valid),
                .src_data_i  (i),
                .valid_o     (v[k]),
                .data_o      (d[k])
            );
        end else begin : g_body
            ff_pipe_stage #(.N(N), .RST_DATA(RST_DATA)) u_stage (
                .clk_i       (CLK),
                .rst_i       (rst),
                .flush_i     (flush),
                .load_i      (ready[k]),
                .src_valid_i (v[k-1]),
                .src_data_i  (d[k-1]),
                .valid_o     (v[k]),
                .data_o      (d[k])
            );
        end
    end

    assign in_ready  = ready[0] & !flush;
    assign out_valid = v[DEPTH-1];
    assign o         = d[DEPTH-1];

    logic accept, take;
    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !take) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (take && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_ff_pipe.sv
module tb_ff_pipe;

    localparam int N     = 64;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [N-1:0] i;
    logic         in_ready, out_valid;
    logic [N-1:0] o;
    logic [2:0]   occupancy;

    logic         in_ready0, out_valid0;
    logic [N-1:0] o0;
    logic [2:0]   occupancy0;

    ff_pipe #(.N(N), .DEPTH(DEPTH), .RST_DATA(1'b1)) dut (
        .CLK(CLK), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .i(i),
        .out_valid(out_valid), .out_ready(out_ready), .o(o),
        .occupancy(occupancy)
    );

    ff_pipe #(.N(N), .DEPTH(DEPTH), .RST_DATA(1'b0)) dut0 (
        .CLK(CLK), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .i(i),
        .out_valid(out_valid0), .out_ready(out_ready), .o(o0),
        .occupancy(occupancy0)
    );

    always #5 CLK = ~CLK;

    logic [N-1:0] exp_q [$];
    logic [N-1:0] exp_d;
    int checks   = 0;
    int failures = 0;
    int accepts  = 0;
    int takes    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // stimulus side of the scoreboard: every accepted word becomes an expectation
    always @(negedge CLK) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(i);
            accepts++;
        end
    end

    // monitor: every take is compared against the oldest expectation
    always @(negedge CLK) begin
        if (!rst && out_valid && out_ready) begin
            takes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_take actual=0x%0h required=no_word", o);
            end else begin
                exp_d = exp_q.pop_front();
                check("scoreboard_data", o, exp_d);
            end
        end
    end

    always @(negedge CLK) begin
        if (!rst) begin
            checks++;
            assert (32'(dut.occupancy) == $countones(dut.v))
            else begin
                failures++;
                $display("FAIL occ_popcount actual=%0d required=%0d", dut.occupancy, $countones(dut.v));
            end
        end
    end

    int a0, t0;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; i = '0;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge CLK);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data_clear", o, 0);
        check("rst_out_valid_nodata", out_valid0, 0);
        tick();

        // 1: streaming with out_ready=1
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            i = 64'(k + 1);
            @(negedge CLK);
            check("t1_in_ready", in_ready, 1);
            if (k == 3) check("t1_no_early_out", out_valid, 0);
            if (k == 4) check("t1_first_word", o, 64'h1);
            if (k >= 4) begin
                check("t1_out_valid", out_valid, 1);
                check("t1_occupancy", occupancy, 4);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check("t1_takes", takes, 16);
        check("t1_drained", occupancy, 0);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: stall, six words offered, four fit
        out_ready = 1'b0;
        a0 = accepts;
        for (int j = 0; j < 6; j++) begin
            in_valid = 1'b1;
            i = 64'h21 + 64'(j);
            @(negedge CLK);
            check("t2_in_ready", in_ready, (j < 4) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        check("t2_accepts", accepts - a0, 4);
        for (int s = 0; s < 3; s++) begin
            @(negedge CLK);
            check("t2_occupancy", occupancy, 4);
            check("t2_out_valid", out_valid, 1);
            check("t2_o_held", o, 64'h21);
            check("t2_in_ready_low", in_ready, 0);
            tick();
        end

        // 3: full pipe, simultaneous accept and take
        a0 = accepts;
        t0 = takes;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            i = 64'h31 + 64'(j);
            @(negedge CLK);
            check("t3_in_ready", in_ready, 1);
            check("t3_out_valid", out_valid, 1);
            check("t3_occupancy", occupancy, 4);
            tick();
        end
        in_valid = 1'b0;
        check("t3_accepts", accepts - a0, 8);
        check("t3_takes", takes - t0, 8);
        repeat (6) tick();
        check("t3_drained", occupancy, 0);

        // 4: bubble collapse under stall
        out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            in_valid = 1'b1;
            i = 64'h41 + 64'(j);
            @(negedge CLK);
            check("t4_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        @(negedge CLK);
        check("t4_stage_valids", dut.v, 4'b1100);
        check("t4_occupancy", occupancy, 2);
        check("t4_o", o, 64'h41);
        tick();
        out_ready = 1'b1;
        @(negedge CLK);
        check("t4_take1_valid", out_valid, 1);
        check("t4_take1_data", o, 64'h41);
        tick();
        @(negedge CLK);
        check("t4_take2_valid", out_valid, 1);
        check("t4_take2_data", o, 64'h42);
        tick();
        @(negedge CLK);
        check("t4_empty", out_valid, 0);
        check("t4_occ_zero", occupancy, 0);
        tick();

        // 5: flush at occupancy 3
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            i = 64'h51 + 64'(j);
            tick();
        end
        flush = 1'b1;
        in_valid = 1'b1;
        i = 64'h5F;
        @(negedge CLK);
        check("t5_occ_before_flush", occupancy, 3);
        check("t5_in_ready_flush", in_ready, 0);
        tick();
        flush = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 0);
            i = 64'h54;
            @(negedge CLK);
            if (k == 0) begin
                check("t5_out_valid_flushed", out_valid, 0);
                check("t5_occ_flushed", occupancy, 0);
                check("t5_in_ready_after", in_ready, 1);
            end
            if (k == 3) check("t5_no_early_out", out_valid, 0);
            if (k == 4) begin
                check("t5_latency_valid", out_valid, 1);
                check("t5_latency_data", o, 64'h54);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // 6: reset mid-stream, with and without data clearing
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            i = 64'h61 + 64'(k);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge CLK);
        check("t6_o_before_rst", o, 64'h63);
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        check("t6_out_valid", out_valid, 0);
        check("t6_occupancy", occupancy, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_o_cleared", o, 0);
        check("t6_nodata_out_valid", out_valid0, 0);
        check("t6_nodata_occupancy", occupancy0, 0);
        check("t6_nodata_o_held", o0, 64'h63);
        tick();
        repeat (2) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
